imuldiv_int_mul_iter_param: RTL and testbench

- Parametrised, mode-selectable iterative shift-add multiplier. It is the successor to the fixed 32-bit signed iterative multiply unit.
- Computes the full 2W-bit product of two W-bit operands in one of three signedness modes: unsigned×unsigned, signed×signed, and signed(a)×unsigned(b).
- Optionally terminates early once no set bits of |b| remain.
- Sits in the imuldiv unit behind val/rdy request and response channels; it serves MUL, MULH, MULHSU and MULHU via the low or high half of the result.

---
 rtl/imuldiv_int_mul_iter_param.sv | 114 +++++++++++
 tb/tb_imuldiv_int_mul_iter_param.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_int_mul_iter_param.sv
// Iterative shift-add multiplier producing the full 2W-bit product in uu, ss or su mode.
// Works on operand magnitudes and applies the sign to the product on the way out.
module imuldiv_int_mul_iter_param #(
    parameter int unsigned W          = 32,
    parameter int unsigned EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     mulreq_msg_a,
    input  logic [W-1:0]     mulreq_msg_b,
    input  logic [1:0]       mulreq_msg_fn,
    input  logic             mulreq_val,
    output logic             mulreq_rdy,
    output logic [2*W-1:0]   mulresp_msg_result,
    output logic             mulresp_val,
    input  logic             mulresp_rdy
);

    localparam int unsigned   W2       = 2 * W;
    localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W2-1:0]   a_q, a_d;
    logic [W2-1:0]   result_q, result_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;

    logic            a_neg_c, b_neg_c;
    logic [W-1:0]    a_mag_c, b_mag_c;

    // Operand sign detection and magnitude; fn 3 falls through as unsigned.
    always_comb begin
        a_neg_c = mulreq_msg_a[W-1] && ((mulreq_msg_fn == 2'd1) || (mulreq_msg_fn == 2'd2));
        b_neg_c = mulreq_msg_b[W-1] && (mulreq_msg_fn == 2'd1);
        a_mag_c = a_neg_c ? (~mulreq_msg_a + W'(1)) : mulreq_msg_a;
        b_mag_c = b_neg_c ? (~mulreq_msg_b + W'(1)) : mulreq_msg_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    // Next state, datapath update and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        mulreq_rdy  = 1'b0;
        mulresp_val = 1'b0;

        case (state_q)
            IDLE: begin
                mulreq_rdy = 1'b1;
                if (mulreq_val) begin
                    state_d  = CALC;
                    a_d      = {{W{1'b0}}, a_mag_c};
                    b_d      = b_mag_c;
                    result_d = '0;
                    cnt_d    = '0;
                    sign_d   = a_neg_c ^ b_neg_c;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    result_d = result_q + a_q;
                end
                a_d   = {a_q[W2-2:0], 1'b0};
                b_d   = {1'b0, b_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Early exit once no multiplier bits remain beyond the one consumed now.
                if ((cnt_q == CNT_LAST) || ((EARLY_TERM != 0) && (b_q[W-1:1] == '0))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                mulresp_val = 1'b1;
                if (mulresp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mulresp_msg_result = sign_q ? (~result_q + W2'(1)) : result_q;

endmodule

// File: tb/tb_imuldiv_int_mul_iter_param.sv
// Self-checking bench: four multiplier instances (W=32/8, EARLY_TERM=1/0) driven in lockstep
// and compared with an arithmetic reference model for product and latency.
module tb_imuldiv_int_mul_iter_param;

    logic        clk;
    logic        reset;
    logic [31:0] a32, b32;
    logic [1:0]  fn;
    logic        req_val;
    logic        resp_rdy;
    logic [3:0]  rdy_v, val_v;
    logic [63:0] r0, r1;
    logic [15:0] r2, r3;
    logic [63:0] res_arr [4];

    int n_checks;
    int n_fail;

    logic [63:0] got_res [4];
    int          got_lat [4];
    int unsigned w_of [4] = '{32, 32, 8, 8};
    int unsigned et_of [4] = '{1, 0, 1, 0};

    assign res_arr[0] = r0;
    assign res_arr[1] = r1;
    assign res_arr[2] = {48'd0, r2};
    assign res_arr[3] = {48'd0, r3};

    imuldiv_int_mul_iter_param #(.W(32), .EARLY_TERM(1)) u_m32e (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a32), .mulreq_msg_b(b32), .mulreq_msg_fn(fn),
        .mulreq_val(req_val), .mulreq_rdy(rdy_v[0]),
        .mulresp_msg_result(r0), .mulresp_val(val_v[0]), .mulresp_rdy(resp_rdy)
    );
    imuldiv_int_mul_iter_param #(.W(32), .EARLY_TERM(0)) u_m32f (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a32), .mulreq_msg_b(b32), .mulreq_msg_fn(fn),
        .mulreq_val(req_val), .mulreq_rdy(rdy_v[1]),
        .mulresp_msg_result(r1), .mulresp_val(val_v[1]), .mulresp_rdy(resp_rdy)
    );
    imuldiv_int_mul_iter_param #(.W(8), .EARLY_TERM(1)) u_m8e (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a32[7:0]), .mulreq_msg_b(b32[7:0]), .mulreq_msg_fn(fn),
        .mulreq_val(req_val), .mulreq_rdy(rdy_v[2]),
        .mulresp_msg_result(r2), .mulresp_val(val_v[2]), .mulresp_rdy(resp_rdy)
    );
    imuldiv_int_mul_iter_param #(.W(8), .EARLY_TERM(0)) u_m8f (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a32[7:0]), .mulreq_msg_b(b32[7:0]), .mulreq_msg_fn(fn),
        .mulreq_val(req_val), .mulreq_rdy(rdy_v[3]),
        .mulresp_msg_result(r3), .mulresp_val(val_v[3]), .mulresp_rdy(resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand value as a mathematical integer under the given width and signedness.
    function automatic logic signed [95:0] op_val(input int unsigned w, input logic [31:0] x,
                                                  input bit is_signed);
        logic [31:0]        wm;
        logic signed [95:0] v;
        wm = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v  = $signed({64'd0, x & wm});
        if (is_signed && x[w-1]) v = v - (96'sd1 <<< w);
        return v;
    endfunction

    function automatic logic [63:0] ref_mul(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic [1:0] f);
        logic signed [95:0] sa, sb, p;
        logic [95:0]        m, pu;
        sa = op_val(w, a, (f == 2'd1) || (f == 2'd2));
        sb = op_val(w, b, f == 2'd1);
        p  = sa * sb;
        m  = (96'd1 << (2 * w)) - 96'd1;
        pu = 96'(p) & m;
        return pu[63:0];
    endfunction

    function automatic int ref_lat(input int unsigned w, input int unsigned et,
                                   input logic [31:0] b, input logic [1:0] f);
        logic signed [95:0] sb;
        logic [95:0]        mag;
        int                 lat;
        if (et == 0) return int'(w);
        sb  = op_val(w, b, f == 2'd1);
        mag = (sb < 0) ? 96'(-sb) : 96'(sb);
        lat = 1;
        for (int k = 0; k < int'(w); k++) if (mag[k]) lat = k + 1;
        return lat;
    endfunction

    // Issue one request to all instances (call at a negedge) and capture each response.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        logic [3:0] done;
        done = 4'h0;
        for (int i = 0; i < 4; i++) begin
            got_res[i] = 64'hDEAD_BEEF_DEAD_BEEF;
            got_lat[i] = -1;
        end
        a32 = a; b32 = b; fn = f; req_val = 1'b1; resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        a32 = $urandom; b32 = $urandom; fn = 2'($urandom_range(0, 3));
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!done[i] && val_v[i]) begin
                    done[i]    = 1'b1;
                    got_lat[i] = k;
                    got_res[i] = res_arr[i];
                end
            end
            if (done == 4'hF) break;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdy_v[i] !== 1'b1) begin
                n_fail++; $display("FAIL reset_rdy[%0d]: got %b exp 1", i, rdy_v[i]);
            end
            n_checks++;
            if (val_v[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_val[%0d]: got %b exp 0", i, val_v[i]);
            end
            n_checks++;
            if (res_arr[i] !== 64'd0) begin
                n_fail++; $display("FAIL reset_result[%0d]: got %h exp 0", i, res_arr[i]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb [5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [1:0]  vf [5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [63:0] er [5] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                                64'h0000_0000_FFFF_FFFF, 64'h4000_0000_0000_0000,
                                64'hFFFF_FFFF_0000_0001};
        int          el [5] = '{3, 32, 1, 32, 32};
        for (int t = 0; t < 5; t++) begin
            do_txn(va[t], vb[t], vf[t]);
            n_checks++;
            if (got_res[0] !== er[t]) begin
                n_fail++; $display("FAIL dir_result[%0d]: got %h exp %h", t, got_res[0], er[t]);
            end
            n_checks++;
            if (got_lat[0] !== el[t]) begin
                n_fail++; $display("FAIL dir_latency[%0d]: got %0d exp %0d", t, got_lat[0], el[t]);
            end
            n_checks++;
            if (got_lat[1] !== 32) begin
                n_fail++; $display("FAIL dir_latency_noet[%0d]: got %0d exp 32", t, got_lat[1]);
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (got_res[i] !== ref_mul(w_of[i], va[t], vb[t], vf[t])) begin
                    n_fail++; $display("FAIL dir_model[%0d][%0d]: got %h exp %h", t, i, got_res[i],
                                       ref_mul(w_of[i], va[t], vb[t], vf[t]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp0;
        logic [31:0] na, nb;
        exp0 = 64'hFFFF_FFFF_FFFF_FFEB;
        a32 = 32'hFFFF_FFF9; b32 = 32'd3; fn = 2'd1; req_val = 1'b1; resp_rdy = 1'b0;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        repeat (34) @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (val_v[0] !== 1'b1) begin
                n_fail++; $display("FAIL bp_val[%0d]: got %b exp 1", c, val_v[0]);
            end
            n_checks++;
            if (res_arr[0] !== exp0) begin
                n_fail++; $display("FAIL bp_result[%0d]: got %h exp %h", c, res_arr[0], exp0);
            end
            n_checks++;
            if (rdy_v[0] !== 1'b0) begin
                n_fail++; $display("FAIL bp_reqrdy[%0d]: got %b exp 0", c, rdy_v[0]);
            end
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rdy_v !== 4'hF || val_v !== 4'h0) begin
            n_fail++; $display("FAIL bp_release: got rdy %b val %b exp rdy 1111 val 0000", rdy_v, val_v);
        end
        na = $urandom; nb = $urandom;
        do_txn(na, nb, 2'd2);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_res[i] !== ref_mul(w_of[i], na, nb, 2'd2)) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h exp %h", i, got_res[i],
                                   ref_mul(w_of[i], na, nb, 2'd2));
            end
        end
    endtask

    task automatic test_async_reset();
        int el [4] = '{3, 32, 3, 8};
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; fn = 2'd0; req_val = 1'b1; resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdy_v[i] !== 1'b1 || val_v[i] !== 1'b0 || res_arr[i] !== 64'd0) begin
                n_fail++; $display("FAIL areset[%0d]: got rdy %b val %b res %h exp 1 0 0",
                                   i, rdy_v[i], val_v[i], res_arr[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (val_v !== 4'h0) begin
                n_fail++; $display("FAIL areset_noresp: got val %b exp 0000", val_v);
            end
        end
        do_txn(32'd7, 32'd6, 2'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_res[i] !== 64'd42) begin
                n_fail++; $display("FAIL post_reset_result[%0d]: got %h exp 42", i, got_res[i]);
            end
            n_checks++;
            if (got_lat[i] !== el[i]) begin
                n_fail++; $display("FAIL post_reset_latency[%0d]: got %0d exp %0d", i, got_lat[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic [1:0]  rf;
        for (int t = 0; t < 40; t++) begin
            ra = $urandom; rb = $urandom; rf = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: rb = 32'd0;
                2: rb = 32'($urandom_range(0, 20));
                3: ra = 32'h8080_8080;
                4: rb = 32'hFFFF_FF80;
                default: ;
            endcase
            do_txn(ra, rb, rf);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_res[i] !== ref_mul(w_of[i], ra, rb, rf)) begin
                    n_fail++; $display("FAIL rnd_result[%0d][%0d] a=%h b=%h fn=%0d: got %h exp %h", t, i,
                                       ra, rb, rf, got_res[i], ref_mul(w_of[i], ra, rb, rf));
                end
                n_checks++;
                if (got_lat[i] !== ref_lat(w_of[i], et_of[i], rb, rf)) begin
                    n_fail++; $display("FAIL rnd_latency[%0d][%0d] b=%h fn=%0d: got %0d exp %0d", t, i,
                                       rb, rf, got_lat[i], ref_lat(w_of[i], et_of[i], rb, rf));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        a32      = '0;
        b32      = '0;
        fn       = 2'd0;
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
